mipi_tx_frame_sched: RTL
========================

Name: mipi_tx_frame_sched

Overview:
Frame/line scheduler that sequences the 8-byte PRBS MIPI Tx test-data generator. It produces frame and line timing (VSync/HSync) and the MipiTxDValid enable that advances the PRBS source. It also generates frame-start/end pulses and frame/line counters for the CSI-2 Tx core and the Rx checker. It sits between the test-control registers and the Tx data generator / CSI-2 Tx core.

Parameters:
LineWords_C, 16, MipiTxDValid cycles per active line (>=1)
LineNum_C, 8, active lines per frame (>=1)
FsLead_C, 2, cycles from frame start to the first line (>=1)
HBlank_C, 4, minimum cycles between lines (>=1)
VBlank_C, 8, cycles of frame-end blanking (>=1)

Ports:
SysClk  in  1  system clock; all logic on its rising edge
Reset_N  in  1  asynchronous active-low reset
Start  in  1  start request; level-sampled in IDLE
Stop  in  1  stop request; takes effect at the next frame boundary
FrameTotal  in  16  number of frames to send; 0 = continuous; sampled when Start is accepted
TxReady  in  1  CSI-2 Tx core can accept a line
MipiTxDValid  out  1  data-valid enable to the PRBS Tx data generator
VSync  out  1  frame valid
HSync  out  1  line valid; identical to MipiTxDValid
FrameStart  out  1  one-cycle pulse in the first FS cycle
FrameEnd  out  1  one-cycle pulse in the first VBLK cycle
LineCnt  out  16  index of the current/last line, 0..LineNum_C-1
FrameCnt  out  16  number of completed frames since Start
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (asynchronous, Reset_N=0) clears every output to 0 and returns the FSM to IDLE. This holds in any state, including mid-line. All outputs are registered.
- States: IDLE, FS, LINE, HBLK, VBLK. One down-counter serves as the state timer.
- IDLE:
  - Start=1 -> FS on the next edge. That edge also sets FrameCnt=0, LineCnt=0 and StopPend=0, and latches FrameTotal.
  - Stop in IDLE is ignored.
- Start and Stop high in the same IDLE cycle -> start accepted with StopPend=1, so exactly one frame is sent.
- Start while Busy=1 is ignored.
- FS:
  - VSync=1 for the whole state. FrameStart=1 in the first FS cycle only.
  - Lasts FsLead_C cycles. The state is then extended while TxReady=0.
  - Exits to LINE in the cycle after the timer has expired and TxReady=1 is sampled.
- LINE:
  - HSync=MipiTxDValid=1 for exactly LineWords_C consecutive cycles. TxReady is not checked inside a line.
  - On exit: if LineCnt=LineNum_C-1 -> VBLK; otherwise -> HBLK and LineCnt increments (visible in the first HBLK cycle).
- HBLK:
  - VSync=1, HSync=0.
  - Lasts HBlank_C cycles, extended while TxReady=0 (same rule as FS), then -> LINE.
- VBLK:
  - VSync=0. FrameEnd=1 in the first VBLK cycle, and FrameCnt increments in that same cycle; FrameCnt wraps 0xFFFF -> 0.
  - Lasts VBlank_C cycles. At the end:
    - If StopPend=1 or (latched FrameTotal != 0 and FrameCnt == FrameTotal) -> IDLE, with Done=1 for one cycle and Busy=0 in that cycle.
    - Otherwise -> FS, with LineCnt=0.
- Stop while Busy=1 sets StopPend. The current frame always completes; a frame is never truncated.
- Frame period with defaults and TxReady=1: FsLead_C + LineNum_C*LineWords_C + (LineNum_C-1)*HBlank_C + VBlank_C = 2+128+28+8 = 166 cycles. VSync is high for 158 of them.
- The TxReady wait adds 0 cycles when TxReady is already 1 at timer expiry.

Test Plan:
1. Reset mid-LINE (Reset_N low for 1 cycle) -> all outputs 0 asynchronously, FSM in IDLE, MipiTxDValid=0.
2. FrameTotal=1, Start pulse, TxReady=1:
   - exactly 8 HSync bursts of 16 cycles, separated by 4-cycle gaps;
   - FrameStart at cycle 1 after Start; FrameEnd at cycle 159;
   - Done 166 cycles after the first FS cycle; FrameCnt=1; 128 total MipiTxDValid cycles.
3. FrameTotal=3 -> 3 back-to-back frames of 166 cycles each; FrameCnt goes 1,2,3; a single Done pulse; Busy low after it.
4. FrameTotal=0 (continuous), Stop asserted at line 3 of frame 2 -> frame 2 completes all 8 lines; Done at its VBLK end; FrameCnt=2.
5. TxReady held 0 for 10 cycles across the end of an HBLK -> that HBLK lasts 4+10 cycles; line length stays 16; no MipiTxDValid during the wait.
6. Start and Stop in the same IDLE cycle -> exactly one frame then Done. A Start pulse during Busy -> no effect on counters or timing.

Source files
------------

// File: rtl/mipi_tx_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mipi_tx_frame_sched
//  Description : Frame/line scheduler for the 8-byte PRBS MIPI Tx test-data
//                generator. It produces VSync/HSync frame and line timing and
//                the MipiTxDValid enable that advances the PRBS source. It also
//                produces frame start/end pulses and line/frame counters for
//                the CSI-2 Tx core and the Rx checker.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    SysClk       in   system clock, rising edge
//    Reset_N      in   asynchronous active-low reset
//    Start        in   start request, level-sampled while idle
//    Stop         in   stop request, honoured at the next frame boundary
//    FrameTotal   in   frames to send (0 = continuous), latched at start
//    TxReady      in   CSI-2 Tx core can accept a line
//    MipiTxDValid out  data-valid enable to the PRBS generator
//    VSync        out  frame valid
//    HSync        out  line valid (same as MipiTxDValid)
//    FrameStart   out  pulse in the first FS cycle
//    FrameEnd     out  pulse in the first vertical-blanking cycle
//    LineCnt      out  index of the current/last line
//    FrameCnt     out  completed frames since start
//    Busy         out  high whenever not idle
//    Done         out  pulse on return to idle
// ============================================================================
module mipi_tx_frame_sched #(
    parameter int LINE_WORDS = 16,  // data-valid cycles per active line
    parameter int LINE_NUM   = 8,   // active lines per frame
    parameter int FS_LEAD    = 2,   // frame start to first line
    parameter int H_BLANK    = 4,   // minimum gap between lines
    parameter int V_BLANK    = 8    // frame-end blanking
) (
    input  logic        SysClk,
    input  logic        Reset_N,
    input  logic        Start,
    input  logic        Stop,
    input  logic [15:0] FrameTotal,
    input  logic        TxReady,
    output logic        MipiTxDValid,
    output logic        VSync,
    output logic        HSync,
    output logic        FrameStart,
    output logic        FrameEnd,
    output logic [15:0] LineCnt,
    output logic [15:0] FrameCnt,
    output logic        Busy,
    output logic        Done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FS   = 3'd1;
    localparam logic [2:0] S_LINE = 3'd2;
    localparam logic [2:0] S_HBLK = 3'd3;
    localparam logic [2:0] S_VBLK = 3'd4;

    // Timer load values: a state of length N loads N-1 and ends at zero.
    localparam logic [15:0] c_fsLoad   = 16'(FS_LEAD - 1);
    localparam logic [15:0] c_lineLoad = 16'(LINE_WORDS - 1);
    localparam logic [15:0] c_hLoad    = 16'(H_BLANK - 1);
    localparam logic [15:0] c_vLoad    = 16'(V_BLANK - 1);
    localparam logic [15:0] c_lastLine = 16'(LINE_NUM - 1);

    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic        r_stopPend;
    logic [15:0] r_frameTotal;

    always_ff @(posedge SysClk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_stopPend   <= 1'b0;
            r_frameTotal <= '0;
            MipiTxDValid <= 1'b0;
            VSync        <= 1'b0;
            HSync        <= 1'b0;
            FrameStart   <= 1'b0;
            FrameEnd     <= 1'b0;
            LineCnt      <= '0;
            FrameCnt     <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            FrameStart <= 1'b0;
            FrameEnd   <= 1'b0;
            Done       <= 1'b0;

            // Busy is low only in idle, where the start branch owns r_stopPend.
            if (Busy && Stop) begin
                r_stopPend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state      <= S_FS;
                        r_timer      <= c_fsLoad;
                        r_stopPend   <= Stop;   // same-cycle stop: one frame only
                        r_frameTotal <= FrameTotal;
                        FrameCnt     <= '0;
                        LineCnt      <= '0;
                        VSync        <= 1'b1;
                        Busy         <= 1'b1;
                        FrameStart   <= 1'b1;
                    end
                end

                S_FS, S_HBLK: begin
                    // Minimum duration first, then hold until the Tx core is ready.
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 16'd1;
                    end else if (TxReady) begin
                        r_state      <= S_LINE;
                        r_timer      <= c_lineLoad;
                        HSync        <= 1'b1;
                        MipiTxDValid <= 1'b1;
                    end
                end

                S_LINE: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 16'd1;
                    end else begin
                        HSync        <= 1'b0;
                        MipiTxDValid <= 1'b0;
                        if (LineCnt == c_lastLine) begin
                            r_state  <= S_VBLK;
                            r_timer  <= c_vLoad;
                            VSync    <= 1'b0;
                            FrameEnd <= 1'b1;
                            FrameCnt <= FrameCnt + 16'd1;
                        end else begin
                            r_state <= S_HBLK;
                            r_timer <= c_hLoad;
                            LineCnt <= LineCnt + 16'd1;
                        end
                    end
                end

                S_VBLK: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 16'd1;
                    end else if (r_stopPend ||
                                 ((r_frameTotal != '0) && (FrameCnt == r_frameTotal))) begin
                        r_state <= S_IDLE;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                    end else begin
                        r_state    <= S_FS;
                        r_timer    <= c_fsLoad;
                        LineCnt    <= '0;
                        VSync      <= 1'b1;
                        FrameStart <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_timer      <= '0;
                    VSync        <= 1'b0;
                    HSync        <= 1'b0;
                    MipiTxDValid <= 1'b0;
                    Busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
